mdu_iterative: RTL and testbench

- Iterative multiply/divide unit for the execute stage; sits beside the ALU and takes the same rs/rt operands from the register-file read path.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles: shift-add for multiply, restoring algorithm for divide.
- Holds the architectural HI/LO registers, which feed the writeback mux for MFHI/MFLO.
- Also services MTHI/MTLO writes.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_fsm.sv | 71 +++++++
 rtl/mdu_iterative.sv | 157 +++++++++++++++
 tb/tb_mdu_iterative.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op encodings driven on the mdu_iterative op port
//   - FSM state encoding used by mdu_fsm
//   - default datapath width and iteration counter width
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;
  localparam int unsigned MDU_CNT_W = 5;  // log2(MDU_WIDTH)

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StFix  = 2'b10,
    StDone = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mdu_fsm.sv
// Sequencer for the iterative multiply/divide unit.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start_i     - operation request, only honoured in idle
//   idle_o      - FSM is idle (MTHI/MTLO writes allowed)
//   load_o      - operand latch strobe (idle and start)
//   calc_o      - one iteration is performed on this edge
//   fix_o       - sign correction / HI-LO write on this edge
//   busy_o      - operation in progress (calc or fix)
//   done_o      - one-cycle completion pulse
module mdu_fsm
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH,
  parameter int unsigned CNT_W = MDU_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  output logic idle_o,
  output logic load_o,
  output logic calc_o,
  output logic fix_o,
  output logic busy_o,
  output logic done_o
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StCalc;
          cnt_d   = '0;
          load_o  = 1'b1;
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign idle_o = (state_q == StIdle);
  assign calc_o = (state_q == StCalc);
  assign fix_o  = (state_q == StFix);
  assign busy_o = calc_o | fix_o;
  assign done_o = (state_q == StDone);

endmodule

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division, one bit per
// cycle on magnitudes; signs are applied in a final correction cycle.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   start, op       - begin operation (idle only); 00 MULT 01 MULTU 10 DIV 11 DIVU
//   rs, rt          - multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we    - MTHI/MTLO strobes (idle only, start has priority)
//   wdata           - MTHI/MTLO data
//   busy, done      - in progress / one-cycle completion pulse
//   div_zero        - with done, divide had rt == 0
//   hi, lo          - HI/LO registers
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH,
  parameter int unsigned CNT_W = MDU_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic idle, load, calc, fix;

  mdu_fsm #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_fsm (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start),
    .idle_o (idle),
    .load_o (load),
    .calc_o (calc),
    .fix_o  (fix),
    .busy_o (busy),
    .done_o (done)
  );

  // Operand decode and magnitudes
  mdu_op_e          op_e;
  logic             signed_op, is_div, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_abs, rt_abs;

  assign op_e      = mdu_op_e'(op);
  assign signed_op = (op_e == MDU_MULT) || (op_e == MDU_DIV);
  assign is_div    = (op_e == MDU_DIV) || (op_e == MDU_DIVU);
  assign rs_neg    = signed_op & rs[WIDTH-1];
  assign rt_neg    = signed_op & rt[WIDTH-1];
  assign rs_abs    = rs_neg ? -rs : rs;
  assign rt_abs    = rt_neg ? -rt : rt;

  // Datapath state: {acc_hi, acc_lo} is the product/partial-remainder:quotient pair
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  // Partial remainder stays below the divisor, so bit WIDTH of the difference is the borrow
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign prod      = {acc_hi_q, acc_lo_q};
  assign prod_fix  = neg_res_q ? -prod : prod;
  assign quot_fix  = neg_res_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix   = neg_rem_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (load) begin
      is_div_d  = is_div;
      dz_d      = is_div && (rt == '0);
      neg_res_d = rs_neg ^ rt_neg;
      neg_rem_d = rs_neg;
      acc_hi_d  = '0;
      opnd_d    = rt_abs;
      // Divide by zero parks the raw dividend so HI can return it untouched
      acc_lo_d  = (is_div && (rt == '0)) ? rs : rs_abs;
    end else if (calc && !dz_q) begin
      if (is_div_q) begin
        acc_hi_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
      end else begin
        acc_hi_d = mul_sum[WIDTH:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      end
    end else if (fix) begin
      if (dz_q) begin
        hi_d = acc_lo_q;
        lo_d = '1;
      end else if (is_div_q) begin
        hi_d = rem_fix;
        lo_d = quot_fix;
      end else begin
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
      end
    end else if (idle && !start) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = done & dz_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: latency, results, MTHI/MTLO interplay, reset abort.
module tb_mdu_iterative;

  logic        clk, rst_n, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] rs, rt, wdata;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  mdu_iterative dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs      (rs),
    .rt      (rt),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive start through E0; returns at the negedge after E0 with inputs scrambled.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic with_lo_we, input logic [31:0] wd);
    @(negedge clk);
    op = o; rs = a; rt = b; start = 1'b1; lo_we = with_lo_we; wdata = wd;
    @(posedge clk);
    #1 chk1("busy_at_e0", busy, 1'b1);
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    op = ~o; rs = $urandom; rt = $urandom;  // latched copies must be used from here on
  endtask

  // Run from edge at_edge to E34, checking done timing and the result.
  task automatic complete(input string tag, input int at_edge, input logic [31:0] eh,
                          input logic [31:0] el, input logic edz);
    int early = 0;
    for (int e = at_edge + 1; e <= 32; e++) begin
      @(posedge clk);
      #1 if (done || !busy) early++;
    end
    chk32({tag, "_early_done"}, 32'(early), 32'd0);
    @(posedge clk);  // E33
    #1;
    chk1({tag, "_done"}, done, 1'b1);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_dz"}, div_zero, edz);
    chk32({tag, "_hi"}, hi, eh);
    chk32({tag, "_lo"}, lo, el);
    @(posedge clk);  // E34
    #1 chk1({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; rs = '0; rt = '0; wdata = '0;
    #12;
    chk32("rst_hi", hi, 32'h0);
    chk32("rst_lo", lo, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_dz", div_zero, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0);
    complete("multu_max", 0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

    launch(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 32'h0);
    complete("mult_neg", 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);

    launch(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h0);
    complete("div_neg", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

    launch(2'b11, 32'd100, 32'd0, 1'b0, 32'h0);
    complete("divu_zero", 0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);

    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0);
    complete("div_ovf", 0, 32'h0000_0000, 32'h8000_0000, 1'b0);

    launch(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0, 32'h0);
    complete("div_zero_neg", 0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

    launch(2'b11, 32'd100, 32'd7, 1'b0, 32'h0);
    complete("divu_100_7", 0, 32'd2, 32'd14, 1'b0);

    launch(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'h0);
    complete("div_7_m2", 0, 32'd1, 32'hFFFF_FFFD, 1'b0);

    // MTHI during busy is ignored; a second start at E5 is ignored.
    launch(2'b01, 32'h0001_0000, 32'h0003_0000, 1'b0, 32'h0);
    @(posedge clk);  // E1
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk);  // E2
    #1 chk32("busy_mthi_hi", hi, 32'd1);
    @(negedge clk) hi_we = 1'b0;
    @(posedge clk);  // E3
    @(posedge clk);  // E4
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs = 32'd9; rt = 32'd9;
    @(posedge clk);  // E5
    @(negedge clk) start = 1'b0;
    complete("restart_ign", 5, 32'd3, 32'd0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (done || busy) cnt++;
    end
    chk32("restart_no_2nd", 32'(cnt), 32'd0);

    // MTHI and MTLO together in idle
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234;
    @(posedge clk);
    #1;
    chk32("idle_mthi", hi, 32'h1234);
    chk32("idle_mtlo", lo, 32'h1234);
    @(negedge clk) begin hi_we = 1'b0; lo_we = 1'b0; end

    // start wins over a coincident MTLO
    launch(2'b01, 32'h0000_1000, 32'd3, 1'b1, 32'hBEEF);
    chk32("start_lowe_lo_e0", lo, 32'h1234);
    complete("start_lowe", 0, 32'd0, 32'h3000, 1'b0);

    // Reset at E10 of a DIVU aborts it
    launch(2'b11, 32'd1000, 32'd3, 1'b0, 32'h0);
    for (int e = 1; e <= 10; e++) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk32("abort_hi", hi, 32'h0);
    chk32("abort_lo", lo, 32'h0);
    chk1("abort_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (done || busy || hi != 0 || lo != 0) cnt++;
    end
    chk32("abort_quiet", 32'(cnt), 32'd0);

    launch(2'b01, 32'd6, 32'd7, 1'b0, 32'h0);
    complete("post_rst_mul", 0, 32'd0, 32'd42, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
